// File: rtl/vdp_vram_port_if.sv
// vdp_vram_port_if: bus bundle between the VRAM arbiter and its environment.
//   slave  modport: the arbiter (vdp_vram_port).
//   master modport: the VDP fetch engine, the CPU port and the VRAM macro together.
//   Groups: VDP DMA fetch (vdp_dma_*, vram_dout), CPU port (cpu_*),
//   VDP register write (reg_*), and the synchronous VRAM (mem_*).
//   The cpu_overrun flag exists only when VDP_VRAM_OVERRUN_EN is defined.
interface vdp_vram_port_if #(
    parameter int unsigned AW = 13
);
    logic [AW-1:0] vdp_dma_addr;
    logic          vdp_dma_rd_tick;
    logic [7:0]    vram_dout;
    logic          cpu_wr_tick;
    logic          cpu_rd_tick;
    logic          cpu_mode;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_busy;
    logic          reg_wr_tick;
    logic [2:0]    reg_num;
    logic [7:0]    reg_data;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic [7:0]    mem_dout;
`ifdef VDP_VRAM_OVERRUN_EN
    logic          cpu_overrun;
`endif

    modport slave (
        input  vdp_dma_addr, vdp_dma_rd_tick, cpu_wr_tick, cpu_rd_tick,
        input  cpu_mode, cpu_din, mem_dout,
        output vram_dout, cpu_dout, cpu_busy, reg_wr_tick, reg_num, reg_data,
        output mem_addr, mem_din, mem_we
`ifdef VDP_VRAM_OVERRUN_EN
        , output cpu_overrun
`endif
    );

    modport master (
        output vdp_dma_addr, vdp_dma_rd_tick, cpu_wr_tick, cpu_rd_tick,
        output cpu_mode, cpu_din, mem_dout,
        input  vram_dout, cpu_dout, cpu_busy, reg_wr_tick, reg_num, reg_data,
        input  mem_addr, mem_din, mem_we
`ifdef VDP_VRAM_OVERRUN_EN
        , input cpu_overrun
`endif
    );
endinterface

// File: rtl/vdp_vram_port.sv
// vdp_vram_port: single-port VRAM arbiter shared by VDP DMA fetch and the CPU.
//   pxclk   : sole clock, rising edge.
//   reset_n : asynchronous active-low reset.
//   bus     : vdp_vram_port_if.slave (DMA fetch, CPU data/control port,
//             VDP register write strobe, synchronous VRAM with 1-cycle read).
// DMA reads always win; one CPU operation may be pending and runs in the first
// cycle without a DMA read. The control port uses a two-byte address latch.
// Optional feature: define VDP_VRAM_OVERRUN_EN to add a sticky cpu_overrun flag.
module vdp_vram_port #(
    parameter int VRAM_SIZE = 8192
) (
    input  logic             pxclk,
    input  logic             reset_n,
    vdp_vram_port_if.slave   bus
);
    localparam int unsigned AW = $clog2(VRAM_SIZE);

    typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR, OP_CAP} op_t;
    typedef enum logic {LO_WAIT, HI_WAIT} latch_t;

    op_t           op_q, op_d;
    latch_t        latch_q, latch_d;
    logic [AW-1:0] addr_q, addr_d, addr_inc;
    logic [7:0]    lo_q, lo_d;
    logic [7:0]    buf_q, buf_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [2:0]    reg_num_q, reg_num_d;
    logic [7:0]    reg_data_q, reg_data_d;
    logic          reg_wr_q, reg_wr_d;
    logic          busy_q;
    logic [AW-1:0] mem_addr_c;
    logic          mem_we_c;
    logic          strobe;
    logic          accept;

    // busy_q mirrors op_q != OP_NONE, so an accepted strobe never collides with a pending op
    assign strobe   = bus.cpu_wr_tick | bus.cpu_rd_tick;
    assign accept   = strobe & ~busy_q;
    assign addr_inc = (addr_q == AW'(VRAM_SIZE - 1)) ? '0 : addr_q + AW'(1);

    // State registers
    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= OP_NONE;
            latch_q    <= LO_WAIT;
            addr_q     <= '0;
            lo_q       <= '0;
            buf_q      <= '0;
            cpu_dout_q <= '0;
            wdata_q    <= '0;
            reg_num_q  <= '0;
            reg_data_q <= '0;
            reg_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            op_q       <= op_d;
            latch_q    <= latch_d;
            addr_q     <= addr_d;
            lo_q       <= lo_d;
            buf_q      <= buf_d;
            cpu_dout_q <= cpu_dout_d;
            wdata_q    <= wdata_d;
            reg_num_q  <= reg_num_d;
            reg_data_q <= reg_data_d;
            reg_wr_q   <= reg_wr_d;
            busy_q     <= (op_d != OP_NONE);
        end
    end

    // Next state: execute pending op, then decode an accepted CPU strobe
    always_comb begin
        op_d       = op_q;
        latch_d    = latch_q;
        addr_d     = addr_q;
        lo_d       = lo_q;
        buf_d      = buf_q;
        cpu_dout_d = cpu_dout_q;
        wdata_d    = wdata_q;
        reg_num_d  = reg_num_q;
        reg_data_d = reg_data_q;
        reg_wr_d   = 1'b0;
        mem_addr_c = addr_q;
        mem_we_c   = 1'b0;

        if (bus.vdp_dma_rd_tick) begin
            mem_addr_c = bus.vdp_dma_addr;
        end else if (op_q == OP_WR) begin
            mem_we_c = 1'b1;
            buf_d    = wdata_q;
            addr_d   = addr_inc;
            op_d     = OP_NONE;
        end else if (op_q == OP_RD) begin
            addr_d = addr_inc;
            op_d   = OP_CAP;
        end

        // Read data for our address returns regardless of a DMA tick this cycle
        if (op_q == OP_CAP) begin
            buf_d = bus.mem_dout;
            op_d  = OP_NONE;
        end

        if (accept) begin
            if (bus.cpu_wr_tick) begin
                if (bus.cpu_mode) begin
                    if (latch_q == LO_WAIT) begin
                        lo_d    = bus.cpu_din;
                        latch_d = HI_WAIT;
                    end else begin
                        latch_d = LO_WAIT;
                        if (!bus.cpu_din[7]) begin
                            addr_d = AW'({bus.cpu_din[5:0], lo_q});
                            if (!bus.cpu_din[6]) op_d = OP_RD;
                        end else begin
                            reg_wr_d   = 1'b1;
                            reg_num_d  = bus.cpu_din[2:0];
                            reg_data_d = lo_q;
                        end
                    end
                end else begin
                    latch_d = LO_WAIT;
                    wdata_d = bus.cpu_din;
                    op_d    = OP_WR;
                end
            end else if (!bus.cpu_mode) begin
                latch_d    = LO_WAIT;
                cpu_dout_d = buf_q;
                op_d       = OP_RD;
            end
        end
    end

`ifdef VDP_VRAM_OVERRUN_EN
    logic overrun_q;

    // Sticky record of any strobe dropped while busy
    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) overrun_q <= 1'b0;
        else if (strobe && busy_q) overrun_q <= 1'b1;
    end

    assign bus.cpu_overrun = overrun_q;
`endif

    assign bus.vram_dout   = bus.mem_dout;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_we      = mem_we_c;
    assign bus.mem_din     = wdata_q;
    assign bus.cpu_dout    = cpu_dout_q;
    assign bus.cpu_busy    = busy_q;
    assign bus.reg_wr_tick = reg_wr_q;
    assign bus.reg_num     = reg_num_q;
    assign bus.reg_data    = reg_data_q;
endmodule

// File: tb/tb_vdp_vram_port.sv
// tb_vdp_vram_port: directed bench for vdp_vram_port with a behavioural
// synchronous VRAM (1-cycle read latency) attached to the mem_* side.
module tb_vdp_vram_port;
    localparam int unsigned AW = 13;

    logic pxclk;
    logic reset_n;
    logic [7:0] vram [0:8191];
    int vectors = 0;
    int errors  = 0;

    vdp_vram_port_if #(.AW(AW)) bus ();

    vdp_vram_port #(.VRAM_SIZE(8192)) dut (
        .pxclk   (pxclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial pxclk = 1'b0;
    always #5 pxclk = ~pxclk;

    // Behavioural VRAM: read-before-write, registered read data
    always @(posedge pxclk) begin
        logic [7:0] rd;
        rd = vram[bus.mem_addr];
        if (bus.mem_we) vram[bus.mem_addr] = bus.mem_din;
        bus.mem_dout <= rd;
    end

    task automatic step();
        @(posedge pxclk);
        #1;
    endtask

    task automatic cpu_write(input logic mode, input logic [7:0] data);
        bus.cpu_mode    = mode;
        bus.cpu_din     = data;
        bus.cpu_wr_tick = 1'b1;
        step();
        bus.cpu_wr_tick = 1'b0;
        #1;
    endtask

    task automatic cpu_read(input logic mode);
        bus.cpu_mode    = mode;
        bus.cpu_rd_tick = 1'b1;
        step();
        bus.cpu_rd_tick = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        vectors++; if (bus.cpu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h want 0", bus.cpu_busy); end
        vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %h want 0", bus.mem_we); end
        vectors++; if (bus.mem_addr !== 13'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", bus.mem_addr); end
        vectors++; if (bus.cpu_dout !== 8'h00) begin errors++; $display("FAIL reset_cpu_dout got %h want 00", bus.cpu_dout); end
        vectors++; if (bus.reg_wr_tick !== 1'b0) begin errors++; $display("FAIL reset_reg_wr got %h want 0", bus.reg_wr_tick); end
        vectors++; if (bus.mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din got %h want 00", bus.mem_din); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_data_write();
        cpu_write(1'b1, 8'h00);
        cpu_write(1'b1, 8'h48);
        vectors++; if (bus.cpu_busy !== 1'b0) begin errors++; $display("FAIL setup_nobusy got %h want 0", bus.cpu_busy); end
        vectors++; if (bus.mem_addr !== 13'h0800) begin errors++; $display("FAIL setup_addr got %h want 0800", bus.mem_addr); end
        cpu_write(1'b0, 8'h5A);
        vectors++; if (bus.cpu_busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %h want 1", bus.cpu_busy); end
        vectors++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL wr_we got %h want 1", bus.mem_we); end
        vectors++; if (bus.mem_addr !== 13'h0800) begin errors++; $display("FAIL wr_addr got %h want 0800", bus.mem_addr); end
        vectors++; if (bus.mem_din !== 8'h5A) begin errors++; $display("FAIL wr_din got %h want 5a", bus.mem_din); end
        step();
        vectors++; if (bus.cpu_busy !== 1'b0) begin errors++; $display("FAIL wr_done_busy got %h want 0", bus.cpu_busy); end
        vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL wr_done_we got %h want 0", bus.mem_we); end
        vectors++; if (bus.mem_addr !== 13'h0801) begin errors++; $display("FAIL wr_next_addr got %h want 0801", bus.mem_addr); end
        vectors++; if (vram[13'h0800] !== 8'h5A) begin errors++; $display("FAIL wr_vram got %h want 5a", vram[13'h0800]); end
    endtask

    task automatic test_read_ahead();
        vram[13'h0801] = 8'h81;
        vram[13'h0802] = 8'h82;
        cpu_write(1'b1, 8'h01);
        cpu_write(1'b1, 8'h08);
        vectors++; if (bus.mem_addr !== 13'h0801) begin errors++; $display("FAIL rd_exec_addr got %h want 0801", bus.mem_addr); end
        vectors++; if (bus.cpu_busy !== 1'b1) begin errors++; $display("FAIL rd_busy got %h want 1", bus.cpu_busy); end
        step();
        vectors++; if (bus.cpu_busy !== 1'b1) begin errors++; $display("FAIL rd_cap_busy got %h want 1", bus.cpu_busy); end
        vectors++; if (bus.mem_addr !== 13'h0802) begin errors++; $display("FAIL rd_inc_addr got %h want 0802", bus.mem_addr); end
        step();
        vectors++; if (bus.cpu_busy !== 1'b0) begin errors++; $display("FAIL rd_done_busy got %h want 0", bus.cpu_busy); end
        cpu_read(1'b0);
        vectors++; if (bus.cpu_dout !== 8'h81) begin errors++; $display("FAIL rd_data1 got %h want 81", bus.cpu_dout); end
        vectors++; if (bus.mem_addr !== 13'h0802) begin errors++; $display("FAIL rd_fetch_addr got %h want 0802", bus.mem_addr); end
        step();
        step();
        cpu_read(1'b0);
        vectors++; if (bus.cpu_dout !== 8'h82) begin errors++; $display("FAIL rd_data2 got %h want 82", bus.cpu_dout); end
        step();
        step();
    endtask

    task automatic test_reg_write();
        cpu_write(1'b1, 8'h07);
        cpu_write(1'b1, 8'h87);
        vectors++; if (bus.reg_wr_tick !== 1'b1) begin errors++; $display("FAIL reg_tick got %h want 1", bus.reg_wr_tick); end
        vectors++; if (bus.reg_num !== 3'd7) begin errors++; $display("FAIL reg_num got %h want 7", bus.reg_num); end
        vectors++; if (bus.reg_data !== 8'h07) begin errors++; $display("FAIL reg_data got %h want 07", bus.reg_data); end
        step();
        vectors++; if (bus.reg_wr_tick !== 1'b0) begin errors++; $display("FAIL reg_tick_pulse got %h want 0", bus.reg_wr_tick); end
        vectors++; if (bus.mem_addr !== 13'h0804) begin errors++; $display("FAIL reg_addr_kept got %h want 0804", bus.mem_addr); end
    endtask

    task automatic test_dma_priority();
        logic [7:0] exp_dout;
        vram[13'h0100] = 8'hA0;
        vram[13'h0101] = 8'hA1;
        vram[13'h0102] = 8'hA2;
        cpu_write(1'b0, 8'hC3);
        for (int i = 0; i < 3; i++) begin
            bus.vdp_dma_rd_tick = 1'b1;
            bus.vdp_dma_addr    = 13'h0100 + 13'(i);
            #1;
            vectors++; if (bus.mem_addr !== 13'h0100 + 13'(i)) begin errors++; $display("FAIL dma_addr%0d got %h want %h", i, bus.mem_addr, 13'h0100 + 13'(i)); end
            vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL dma_we%0d got %h want 0", i, bus.mem_we); end
            step();
            exp_dout = 8'hA0 + 8'(i);
            vectors++; if (bus.vram_dout !== exp_dout) begin errors++; $display("FAIL dma_dout%0d got %h want %h", i, bus.vram_dout, exp_dout); end
        end
        bus.vdp_dma_rd_tick = 1'b0;
        #1;
        vectors++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL dma_late_we got %h want 1", bus.mem_we); end
        vectors++; if (bus.mem_addr !== 13'h0804) begin errors++; $display("FAIL dma_late_addr got %h want 0804", bus.mem_addr); end
        vectors++; if (bus.mem_din !== 8'hC3) begin errors++; $display("FAIL dma_late_din got %h want c3", bus.mem_din); end
        step();
        vectors++; if (vram[13'h0804] !== 8'hC3) begin errors++; $display("FAIL dma_late_vram got %h want c3", vram[13'h0804]); end
    endtask

    task automatic test_wrap();
        cpu_write(1'b1, 8'hFF);
        cpu_write(1'b1, 8'h5F);
        cpu_write(1'b0, 8'h11);
        vectors++; if (bus.mem_addr !== 13'h1FFF) begin errors++; $display("FAIL wrap_first got %h want 1fff", bus.mem_addr); end
        step();
        // Simultaneous read and write strobes must behave as a write
        bus.cpu_rd_tick = 1'b1;
        cpu_write(1'b0, 8'h22);
        bus.cpu_rd_tick = 1'b0;
        vectors++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL wrap_we got %h want 1", bus.mem_we); end
        vectors++; if (bus.mem_addr !== 13'h0000) begin errors++; $display("FAIL wrap_second got %h want 0000", bus.mem_addr); end
        vectors++; if (bus.mem_din !== 8'h22) begin errors++; $display("FAIL wrap_din got %h want 22", bus.mem_din); end
        step();
        vectors++; if (vram[13'h1FFF] !== 8'h11) begin errors++; $display("FAIL wrap_vram_top got %h want 11", vram[13'h1FFF]); end
        vectors++; if (vram[13'h0000] !== 8'h22) begin errors++; $display("FAIL wrap_vram_zero got %h want 22", vram[13'h0000]); end
    endtask

    task automatic test_overrun_reset();
        vram[13'h0011] = 8'hEE;
        cpu_write(1'b1, 8'h10);
        cpu_write(1'b1, 8'h40);
        cpu_write(1'b0, 8'h33);
        cpu_write(1'b0, 8'h99);
        vectors++; if (bus.cpu_busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %h want 0", bus.cpu_busy); end
        vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL drop_we got %h want 0", bus.mem_we); end
        vectors++; if (bus.mem_addr !== 13'h0011) begin errors++; $display("FAIL drop_addr got %h want 0011", bus.mem_addr); end
        vectors++; if (vram[13'h0010] !== 8'h33) begin errors++; $display("FAIL drop_vram got %h want 33", vram[13'h0010]); end
`ifdef VDP_VRAM_OVERRUN_EN
        vectors++; if (bus.cpu_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %h want 1", bus.cpu_overrun); end
`endif
        bus.vdp_dma_rd_tick = 1'b1;
        bus.vdp_dma_addr    = 13'h0200;
        cpu_write(1'b0, 8'h44);
        vectors++; if (bus.cpu_busy !== 1'b1) begin errors++; $display("FAIL hold_busy got %h want 1", bus.cpu_busy); end
        reset_n = 1'b0;
        #1;
        vectors++; if (bus.cpu_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %h want 0", bus.cpu_busy); end
        bus.vdp_dma_rd_tick = 1'b0;
        #1;
        vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %h want 0", bus.mem_we); end
        vectors++; if (bus.mem_addr !== 13'h0000) begin errors++; $display("FAIL rst_addr got %h want 0000", bus.mem_addr); end
        vectors++; if (bus.reg_num !== 3'd0) begin errors++; $display("FAIL rst_reg_num got %h want 0", bus.reg_num); end
        vectors++; if (bus.reg_data !== 8'h00) begin errors++; $display("FAIL rst_reg_data got %h want 00", bus.reg_data); end
        vectors++; if (bus.cpu_dout !== 8'h00) begin errors++; $display("FAIL rst_cpu_dout got %h want 00", bus.cpu_dout); end
        vectors++; if (bus.mem_din !== 8'h00) begin errors++; $display("FAIL rst_mem_din got %h want 00", bus.mem_din); end
`ifdef VDP_VRAM_OVERRUN_EN
        vectors++; if (bus.cpu_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %h want 0", bus.cpu_overrun); end
`endif
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        vectors++; if (vram[13'h0011] !== 8'hEE) begin errors++; $display("FAIL rst_no_write got %h want ee", vram[13'h0011]); end
        vectors++; if (bus.cpu_busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %h want 0", bus.cpu_busy); end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) vram[i] = 8'h00;
        reset_n             = 1'b0;
        bus.vdp_dma_addr    = '0;
        bus.vdp_dma_rd_tick = 1'b0;
        bus.cpu_wr_tick     = 1'b0;
        bus.cpu_rd_tick     = 1'b0;
        bus.cpu_mode        = 1'b0;
        bus.cpu_din         = 8'h00;
        test_reset();
        test_data_write();
        test_read_ahead();
        test_reg_write();
        test_dma_priority();
        test_wrap();
        test_overrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/vdp_vram_port.md
VDP_VRAM_PORT -- requirements
Module: vdp_vram_port

Interface
REQ-001 SHALL have parameter VRAM_SIZE, default 8192, VRAM bytes; AW = $clog2(VRAM_SIZE).
REQ-002 SHALL have ports:
- pxclk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vdp_dma_addr  in  AW  VDP fetch address.
- vdp_dma_rd_tick  in  1  VDP read request, one cycle.
- vram_dout  out  8  VDP read data.
- cpu_wr_tick  in  1  CPU write strobe, one cycle, pre-synchronized.
- cpu_rd_tick  in  1  CPU read strobe, one cycle, pre-synchronized.
- cpu_mode  in  1  0 = data port, 1 = control port.
- cpu_din  in  8  CPU write byte.
- cpu_dout  out  8  read-ahead buffer.
- cpu_busy  out  1  CPU VRAM operation pending.
- reg_wr_tick  out  1  VDP register write strobe.
- reg_num  out  3  VDP register number.
- reg_data  out  8  VDP register value.
- mem_addr  out  AW  VRAM address.
- mem_din  out  8  VRAM write data.
- mem_we  out  1  VRAM write enable.
- mem_dout  in  8  VRAM read data, 1-cycle synchronous latency.

Function
REQ-003 SHALL drive vram_dout = mem_dout combinationally; data is valid the cycle after vdp_dma_rd_tick.
REQ-004 SHALL give DMA absolute priority: when vdp_dma_rd_tick=1, mem_addr = vdp_dma_addr and mem_we = 0 in that same cycle.
REQ-005 SHALL hold at most one pending CPU operation (PEND_RD or PEND_WR) and execute it in the first cycle with vdp_dma_rd_tick=0.
REQ-006 SHALL assert cpu_busy from the cycle after a CPU request until the cycle after execution (WR) or after buffer capture (RD).
REQ-007 SHALL run a control-port latch FSM: LO_WAIT -> (control write) -> HI_WAIT, latching cpu_din as lo_byte; next control write returns to LO_WAIT.
REQ-008 On second control byte: bits[7:6]=00 SHALL set addr = {b[5:0],lo_byte} truncated to AW bits and schedule PEND_RD.
REQ-009 On second control byte: bits[7:6]=01 SHALL set addr identically and schedule nothing.
REQ-010 On second control byte: bit7=1 SHALL pulse reg_wr_tick one cycle with reg_num=b[2:0] and reg_data=lo_byte; addr is unchanged.
REQ-011 Any data-port access SHALL force the latch FSM to LO_WAIT.
REQ-012 Data write SHALL schedule PEND_WR; at execution, mem_addr=addr, mem_din=byte, mem_we=1, buffer=byte, addr+1.
REQ-013 Data read SHALL present the current buffer on cpu_dout, then schedule PEND_RD.
REQ-014 PEND_RD execution SHALL issue mem_addr=addr, capture mem_dout into buffer on the next cycle, and increment addr.
REQ-015 addr SHALL wrap from VRAM_SIZE-1 to 0.
REQ-016 A CPU strobe arriving while cpu_busy=1 SHALL be dropped with no state change.
REQ-017 Simultaneous cpu_wr_tick and cpu_rd_tick SHALL be treated as write only.
REQ-018 In idle cycles SHALL hold mem_we=0 and mem_addr=addr.

Reset
REQ-019 reset_n=0 SHALL asynchronously clear: addr, lo_byte, buffer, cpu_dout, reg_num, reg_data, mem_din to 0; cpu_busy, reg_wr_tick, mem_we to 0; latch FSM to LO_WAIT; pending op to none.
REQ-020 Reset mid-operation SHALL abandon any pending op with no VRAM write after reset assertion.

Configuration
REQ-021 With VDP_VRAM_OVERRUN_EN defined, SHALL add output cpu_overrun (1 bit), sticky-set by any drop per REQ-016 and cleared only by reset_n.
REQ-022 Without VDP_VRAM_OVERRUN_EN, the cpu_overrun port SHALL NOT exist and drops are silent.

Verification
REQ-023 Control 0x00 then 0x48, data write 0x5A with rd_tick=0 -> mem_we=1 at addr 0x0800 with mem_din 0x5A; addr becomes 0x0801.
REQ-024 VRAM[0x0801]=0x81, control 0x01 then 0x08 -> buffer=0x81 two cycles after execution; next data read returns 0x81 and fetches 0x0802.
REQ-025 Control 0x07 then 0x87 -> one-cycle reg_wr_tick, reg_num=7, reg_data=0x07; addr unchanged.
REQ-026 Pending write while rd_tick=1 for 3 consecutive cycles -> mem_addr tracks vdp_dma_addr; write issues in cycle 4; vram_dout correct one cycle after each tick.
REQ-027 Write setup to 0x1FFF, two data writes -> writes land at 0x1FFF then 0x0000.
REQ-028 Second data write while cpu_busy -> dropped; cpu_overrun=1 when VDP_VRAM_OVERRUN_EN defined; reset_n low clears all state.
